// File: rtl/lhn_mul_arb_pkg.sv
// Shared types and default parameters for the two-requester multiplier arbiter.
package lhn_mul_arb_pkg;

  localparam int LAT_DEF  = 3;
  localparam int M_W_DEF  = 5;
  localparam int P_W_DEF  = 11;
  localparam int INFL_W   = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } arb_state_e;

  typedef logic req_id_t;

  // Round-robin pick: on contention the requester not granted last wins.
  function automatic req_id_t rr_pick(input logic v0, input logic v1, input req_id_t last_id);
    if (v0 && v1) begin
      return ~last_id;
    end else if (v1) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/lhn_tag_pipe.sv
// LAT-deep {valid,id} shift register that tracks issued operations through the multiplier.
module lhn_tag_pipe
  import lhn_mul_arb_pkg::*;
#(
  parameter int LAT = LAT_DEF
) (
  input  logic    clock,
  input  logic    reset_n,
  input  logic    in_vld,
  input  req_id_t in_id,
  output logic    out_vld,
  output req_id_t out_id
);

  logic    vld_p [LAT];
  req_id_t id_p  [LAT];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LAT; i++) begin
        vld_p[i] <= 1'b0;
        id_p[i]  <= 1'b0;
      end
    end else begin
      // Ids of empty slots are forced to 0 so the output id is 0 whenever invalid.
      vld_p[0] <= in_vld;
      id_p[0]  <= in_vld ? in_id : 1'b0;
      for (int i = 1; i < LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        id_p[i]  <= id_p[i-1];
      end
    end
  end

  assign out_vld = vld_p[LAT-1];
  assign out_id  = id_p[LAT-1];

endmodule

// File: rtl/lhn_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier between two requesters,
// with a drain/halt control FSM and response tagging.
module lhn_mul_arbiter
  import lhn_mul_arb_pkg::*;
#(
  parameter int LAT = LAT_DEF,
  parameter int M_W = M_W_DEF,
  parameter int P_W = P_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [M_W-1:0]    req0_m,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [M_W-1:0]    req1_m,
  output logic              req1_ready,
  input  logic              drain_req,
  output logic [M_W-1:0]    mul_m_bits,
  output logic              mul_issue,
  input  logic [P_W-1:0]    mul_product,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [P_W-1:0]    rsp_product,
  output logic [INFL_W-1:0] inflight,
  output logic              idle
);

  arb_state_e          state_q;
  arb_state_e          state_d;
  logic                grant_en;
  logic                gnt_vld;
  req_id_t             gnt_id;
  req_id_t             last_id_q;
  req_id_t             issue_id_p0;
  logic [INFL_W-1:0]   inflight_d;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (drain_req) state_d = DRAIN;
      DRAIN:   if ((inflight == '0) && !mul_issue) state_d = HALT;
      HALT:    if (!drain_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM outputs; reset_n gates grants so nothing is accepted while reset is held.
  always_comb begin
    grant_en = 1'b0;
    idle     = 1'b0;
    case (state_q)
      RUN:     grant_en = reset_n && !drain_req;
      HALT:    idle     = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    gnt_vld = grant_en && (req0_valid || req1_valid);
    gnt_id  = rr_pick(req0_valid, req1_valid, last_id_q);
  end

  assign req0_ready = gnt_vld && (gnt_id == 1'b0);
  assign req1_ready = gnt_vld && (gnt_id == 1'b1);

  // Stage p0: registered operand toward the multiplier
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mul_issue   <= 1'b0;
      mul_m_bits  <= '0;
      issue_id_p0 <= 1'b0;
      last_id_q   <= 1'b1;
    end else begin
      mul_issue <= gnt_vld;
      if (gnt_vld) begin
        mul_m_bits  <= gnt_id ? req1_m : req0_m;
        issue_id_p0 <= gnt_id;
        last_id_q   <= gnt_id;
      end
    end
  end

  // Stages p1..pLAT: tags travel alongside the multiplier pipeline
  lhn_tag_pipe #(
    .LAT (LAT)
  ) u_tag_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .in_vld  (mul_issue),
    .in_id   (issue_id_p0),
    .out_vld (rsp_valid),
    .out_id  (rsp_id)
  );

  assign rsp_product = mul_product;

  always_comb begin
    case ({mul_issue, rsp_valid})
      2'b10:   inflight_d = inflight + 4'd1;
      2'b01:   inflight_d = inflight - 4'd1;
      default: inflight_d = inflight;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= '0;
    end else begin
      inflight <= inflight_d;
    end
  end

endmodule

// File: tb/tb_lhn_mul_arbiter.sv
// Directed bench for lhn_mul_arbiter driving a 12*M multiplier emulation with LAT=3.
module tb_lhn_mul_arbiter;

  localparam int LAT = 3;
  localparam int M_W = 5;
  localparam int P_W = 11;

  logic           clock;
  logic           reset_n;
  logic           req0_valid;
  logic [M_W-1:0] req0_m;
  logic           req0_ready;
  logic           req1_valid;
  logic [M_W-1:0] req1_m;
  logic           req1_ready;
  logic           drain_req;
  logic [M_W-1:0] mul_m_bits;
  logic           mul_issue;
  logic [P_W-1:0] mul_product;
  logic           rsp_valid;
  logic           rsp_id;
  logic [P_W-1:0] rsp_product;
  logic [3:0]     inflight;
  logic           idle;

  int checks = 0;
  int errors = 0;

  lhn_mul_arbiter #(
    .LAT (LAT),
    .M_W (M_W),
    .P_W (P_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req0_valid  (req0_valid),
    .req0_m      (req0_m),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_m      (req1_m),
    .req1_ready  (req1_ready),
    .drain_req   (drain_req),
    .mul_m_bits  (mul_m_bits),
    .mul_issue   (mul_issue),
    .mul_product (mul_product),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .inflight    (inflight),
    .idle        (idle)
  );

  // lhn_mul12_emu: product = 12*M, LAT cycles after the operand is presented
  logic [P_W-1:0] emu_p [LAT];
  always @(posedge clock) begin
    emu_p[0] <= P_W'(12 * mul_m_bits);
    for (int i = 1; i < LAT; i++) emu_p[i] <= emu_p[i-1];
  end
  assign mul_product = emu_p[LAT-1];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    req0_valid = 1'b1;
    req0_m     = 5'd7;
    req1_valid = 1'b0;
    req1_m     = '0;
    drain_req  = 1'b0;
    #2;
    chk("rst_ready0",   32'(req0_ready), 0);
    chk("rst_ready1",   32'(req1_ready), 0);
    chk("rst_rsp_vld",  32'(rsp_valid), 0);
    chk("rst_rsp_id",   32'(rsp_id), 0);
    chk("rst_idle",     32'(idle), 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_issue",    32'(mul_issue), 0);
    chk("rst_m_bits",   32'(mul_m_bits), 0);
    step();
    reset_n    = 1'b1;
    req0_valid = 1'b0;
    step();

    // Contention: grants 0,1,0,1 then responses 60,120,60,120
    for (int c = 0; c < 8; c++) begin
      req0_valid = (c < 4);
      req1_valid = (c < 4);
      req0_m     = 5'd5;
      req1_m     = 5'd10;
      #1;
      if (c < 4) begin
        chk($sformatf("cont_ready0_%0d", c), 32'(req0_ready), (c % 2 == 0) ? 1 : 0);
        chk($sformatf("cont_ready1_%0d", c), 32'(req1_ready), (c % 2 == 1) ? 1 : 0);
        chk($sformatf("cont_novld_%0d", c),  32'(rsp_valid), 0);
      end else begin
        chk($sformatf("cont_vld_%0d", c),  32'(rsp_valid), 1);
        chk($sformatf("cont_id_%0d", c),   32'(rsp_id), (c % 2 == 0) ? 0 : 1);
        chk($sformatf("cont_prod_%0d", c), 32'(rsp_product), (c % 2 == 0) ? 60 : 120);
      end
      if (c == 4) chk("cont_inflight", 32'(inflight), 3);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    #1;
    chk("cont_inflight_end", 32'(inflight), 0);
    step();

    // Single request: req0 m=15 -> 180 four cycles later
    req0_valid = 1'b1;
    req0_m     = 5'd15;
    #1;
    chk("single_ready0", 32'(req0_ready), 1);
    chk("single_ready1", 32'(req1_ready), 0);
    step();
    req0_valid = 1'b0;
    #1;
    chk("single_issue", 32'(mul_issue), 1);
    chk("single_m_bits", 32'(mul_m_bits), 15);
    for (int k = 1; k <= 4; k++) begin
      step();
      #1;
      if (k < 3) chk($sformatf("single_wait_%0d", k), 32'(rsp_valid), 0);
      if (k == 3) begin
        chk("single_vld",      32'(rsp_valid), 1);
        chk("single_id",       32'(rsp_id), 0);
        chk("single_prod",     32'(rsp_product), 180);
        chk("single_inflight", 32'(inflight), 1);
      end
      if (k == 4) begin
        chk("single_after_vld", 32'(rsp_valid), 0);
        chk("single_after_inf", 32'(inflight), 0);
      end
    end
    step();

    // Drain: three issues, then drain_req stops grants and the pipe empties
    for (int c = 0; c < 10; c++) begin
      req0_valid = 1'b1;
      req0_m     = 5'd3;
      drain_req  = (c >= 3);
      #1;
      chk($sformatf("drain_ready0_%0d", c), 32'(req0_ready), (c < 3) ? 1 : 0);
      if (c >= 4 && c <= 6) begin
        chk($sformatf("drain_vld_%0d", c),  32'(rsp_valid), 1);
        chk($sformatf("drain_prod_%0d", c), 32'(rsp_product), 36);
      end
      if (c == 6) chk("drain_not_idle", 32'(idle), 0);
      if (c == 8) begin
        chk("drain_idle",     32'(idle), 1);
        chk("drain_inflight", 32'(inflight), 0);
        chk("drain_rsp_off",  32'(rsp_valid), 0);
      end
      if (c == 9) chk("halt_hold_idle", 32'(idle), 1);
      step();
    end

    // Resume from HALT with req1 m=1
    req0_valid = 1'b0;
    drain_req  = 1'b0;
    req1_valid = 1'b1;
    req1_m     = 5'd1;
    #1;
    chk("resume_halt_ready1", 32'(req1_ready), 0);
    chk("resume_halt_idle",   32'(idle), 1);
    step();
    #1;
    chk("resume_ready1", 32'(req1_ready), 1);
    chk("resume_idle",   32'(idle), 0);
    step();
    req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (k < 3) begin
        chk($sformatf("resume_wait_%0d", k), 32'(rsp_valid), 0);
      end else begin
        chk("resume_vld",  32'(rsp_valid), 1);
        chk("resume_id",   32'(rsp_id), 1);
        chk("resume_prod", 32'(rsp_product), 12);
      end
      step();
    end
    step();

    // Reset mid-flight: two issues then a one-cycle reset
    req0_valid = 1'b1;
    req0_m     = 5'd2;
    #1;
    chk("mid_ready0_a", 32'(req0_ready), 1);
    step();
    req0_m = 5'd3;
    #1;
    chk("mid_ready0_b", 32'(req0_ready), 1);
    step();
    req0_valid = 1'b0;
    reset_n    = 1'b0;
    #1;
    chk("mid_rst_issue",    32'(mul_issue), 0);
    chk("mid_rst_inflight", 32'(inflight), 0);
    chk("mid_rst_vld",      32'(rsp_valid), 0);
    chk("mid_rst_id",       32'(rsp_id), 0);
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("mid_post_vld_%0d", k), 32'(rsp_valid), 0);
      chk($sformatf("mid_post_inf_%0d", k), 32'(inflight), 0);
      step();
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("mid_cont_ready0", 32'(req0_ready), 1);
    chk("mid_cont_ready1", 32'(req1_ready), 0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lhn_mul_arbiter.md
LHN_MUL_ARBITER -- requirements
Module: lhn_mul_arbiter

Interface
REQ-001 Parameter LAT, default 3, multiplier pipeline latency in cycles (operand presented at cycle t, product valid at t+LAT); legal range 1..8.
REQ-002 Parameter M_W, default 5, multiplier operand width.
REQ-003 Parameter P_W, default 11, multiplier product width.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req0_valid  input  1  requester 0 has an operand pending.
REQ-007 req0_m  input  M_W  requester 0 operand.
REQ-008 req0_ready  output  1  requester 0 operand accepted this cycle.
REQ-009 req1_valid / req1_m / req1_ready  in / in / out  1 / M_W / 1  requester 1, same meaning as requester 0.
REQ-010 drain_req  input  1  stop issuing and empty the multiplier pipeline.
REQ-011 mul_m_bits  output  M_W  registered operand to the lhn_mul12_emu M_bits port.
REQ-012 mul_issue  output  1  mul_m_bits holds a valid operation this cycle.
REQ-013 mul_product  input  P_W  multiplier final_product.
REQ-014 rsp_valid  output  1  rsp_product is the result of an issued operation.
REQ-015 rsp_id  output  1  requester owning the current response (0 or 1).
REQ-016 rsp_product  output  P_W  result, combinational pass-through of mul_product.
REQ-017 inflight  output  4  count of issued operations whose responses are still pending.
REQ-018 idle  output  1  high only in state HALT.

Function
REQ-019 FSM states RUN, DRAIN, HALT; reset state RUN.
REQ-020 RUN: drain_req=1 moves to DRAIN; no grant in the transition cycle.
REQ-021 DRAIN: no grants; moves to HALT when inflight=0 and mul_issue=0; drain_req is ignored in DRAIN.
REQ-022 HALT: no grants; drain_req=0 moves to RUN, first grant possible the following cycle.
REQ-023 Grants are issued only in RUN; reqN_ready is combinational and high only in the cycle requester N is granted.
REQ-024 Arbitration is round-robin: with both valid, grant goes to the requester not granted last; one valid requester is granted every cycle; last-grant register resets to 1, so requester 0 wins the first contention.
REQ-025 On a grant, mul_m_bits <= granted operand and mul_issue <= 1 at the next edge; with no grant, mul_issue <= 0 and mul_m_bits holds its value.
REQ-026 Tag pipeline: {mul_issue, granted id} enters a LAT-deep shift register; rsp_valid/rsp_id are its output stage, aligned with mul_product, giving accept-to-response latency of LAT+1 cycles.
REQ-027 Back-to-back grants sustain one response per cycle; responses are never back-pressured.
REQ-028 inflight increments on mul_issue, decrements on rsp_valid, stays unchanged when both occur in the same cycle; it never exceeds LAT+1.
REQ-029 rsp_id is 0 when rsp_valid=0; rsp_product is don't-care when rsp_valid=0.

Reset
REQ-030 reset_n=0 asynchronously forces state RUN, last-grant=1, mul_issue=0, mul_m_bits=0, all tag stages invalid, inflight=0.
REQ-031 During reset: req0_ready=req1_ready=0, rsp_valid=0, rsp_id=0, idle=0.
REQ-032 Reset asserted mid-operation discards every in-flight tag; no response is produced for operations issued before reset.

Structure
REQ-033 Package lhn_mul_arb_pkg holds the state enum (RUN, DRAIN, HALT), the requester id type, and the LAT/M_W/P_W defaults.
REQ-034 Sub-module lhn_tag_pipe implements the parameterised LAT-deep {valid,id} shift register; the top level instantiates it once.

Verification
REQ-035 All scenarios use LAT=3 and a lhn_mul12_emu model (product = 12*M).
REQ-036 Single request: req0 m=15 -> req0_ready in the same cycle, rsp_valid=1, rsp_id=0, rsp_product=180 four cycles later.
REQ-037 Contention: both valid (m0=5, m1=10) for 4 cycles -> grant order 0,1,0,1; responses 60,120,60,120 on consecutive cycles, ids 0,1,0,1.
REQ-038 Drain: 3 back-to-back issues then drain_req=1 -> no further ready; idle=1 one cycle after the third response; inflight reads 0 in HALT.
REQ-039 Resume: deassert drain_req in HALT with req1 m=1 -> RUN next cycle, req1 granted, rsp_product=12, rsp_id=1.
REQ-040 Reset mid-flight: 2 operations issued, then reset_n=0 for 1 cycle -> rsp_valid stays 0 throughout and afterwards, inflight=0, next contention grants requester 0.
